tdc_capture: RTL and testbench
==============================

// Module: tdc_capture
// PURPOSE
//  Front end of the TDC measurement path. Runs a coarse clock-cycle counter between start and stop events.
//  On stop, latches the delay-line thermometer code and encodes it to a binary fine value.
//  Emits one {int_data, frac_data} pair per measurement with a 1-cycle out_dval strobe.
//  out_dval drives the start input of the downstream x400 multiply/sum stage directly.
// PARAMETERS
//  COARSE_W  10    coarse counter / int_data width
//  FRAC_W    7     frac_data width
//  THERM_W   128   delay-line taps in the thermometer code
//  MAX_CNT   1023  coarse timeout value; must be <= 2**COARSE_W-1
// PORTS
//  clk        in   1         system clock, single clock domain
//  rst        in   1         asynchronous reset, active low
//  tdc_start  in   1         start event, already synchronous to clk, level-sampled
//  tdc_stop   in   1         stop event, already synchronous to clk, level-sampled
//  therm      in   THERM_W   delay-line taps, bit0 nearest the stop launch; valid on the edge tdc_stop is sampled
//  int_data   out  COARSE_W  coarse cycles between start and stop
//  frac_data  out  FRAC_W    encoded fine value
//  out_dval   out  1         1-cycle strobe, int_data/frac_data valid
//  ovf        out  1         current result is a timeout; qualified by out_dval
//  busy       out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset: while rst=0, all outputs are 0, FSM is IDLE, counter and pipeline registers are 0.
//   Reset mid-measurement aborts it; no out_dval is produced for that measurement.
//  FSM states: IDLE, RUN, ENC1, ENC2.
//   IDLE -> RUN on tdc_start=1; coarse counter loads 0.
//   RUN: counter +1 per clk. On tdc_stop=1 at edge P: latch counter value and therm, go to ENC1.
//   RUN: if counter reaches MAX_CNT with no stop, go to ENC1 with the timeout flag set and therm forced to 0.
//   ENC1 -> ENC2 unconditionally (encoder stage 1).
//   ENC2 -> IDLE unconditionally. Registers int_data, frac_data and ovf, and sets out_dval=1 for exactly one cycle.
//  Latency:
//   Stop sampled at edge P -> out_dval high for the cycle after edge P+2.
//   A new tdc_start is accepted at edge P+3 at the earliest.
//  int_data:
//   Start sampled at edge S, stop sampled at edge P -> int_data = P-S cycles; range 1..MAX_CNT.
//   Timeout -> int_data=MAX_CNT, frac_data=0, ovf=1.
//  Ignore rules:
//   tdc_start is ignored in RUN/ENC1/ENC2.
//   tdc_stop is ignored in IDLE/ENC1/ENC2.
//   In RUN, tdc_start and tdc_stop both high in one cycle: stop is processed, start is ignored.
//   tdc_start and tdc_stop both high in IDLE: start is processed, stop is ignored (no zero-length measurement).
//  frac arithmetic:
//   Raw fine count ranges 0..THERM_W; results above 2**FRAC_W-1 saturate to 2**FRAC_W-1 (128 -> 127).
//  Outputs hold their last values between strobes. ovf is cleared on the next non-timeout strobe.
// CONFIGURATION
//  TDC_BUBBLE_FIX_EN defined:
//   fine count = popcount(therm), which is tolerant of bubbles.
//   Stage 1: 8 registered 16-bit group counts. Stage 2: registered sum plus saturation.
//  TDC_BUBBLE_FIX_EN undefined:
//   fine count = index of the highest set bit + 1, or 0 if all bits are 0.
//   Priority encode in stage 1; stage 2 saturates only.
//   Latency is identical in both builds.
// STRUCTURE
//  Package tdc_pkg:
//   COARSE_W/FRAC_W/THERM_W defaults.
//   typedef enum logic[1:0] tdc_state_t {IDLE, RUN, ENC1, ENC2}.
//   typedefs coarse_t and frac_t.
//  Sub-module tdc_therm_enc: 2-stage pipelined thermometer-to-binary encoder with saturation.
//   Holds the TDC_BUBBLE_FIX_EN selection.
//  Top level: FSM, coarse counter, capture registers, output registers.
// TESTING
//  1. Start at edge S, stop at S+37, therm=40 ones
//     -> int_data=37, frac_data=40, ovf=0, out_dval one cycle after S+39.
//  2. No stop after start, MAX_CNT=1023
//     -> int_data=1023, frac_data=0, ovf=1, busy drops after the strobe.
//  3. therm = all 128 ones
//     -> frac_data=127 (saturated).
//  4. therm = 20 ones with bit 9 cleared (bubble)
//     -> frac_data=19 with TDC_BUBBLE_FIX_EN, 20 without.
//  5. Second tdc_start pulsed during RUN and ENC1
//     -> ignored, single strobe. Start at edge P+3 -> accepted and measured correctly.
//  6. rst low during RUN, then released
//     -> no out_dval, all outputs 0, next measurement correct.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and default sizes for the TDC capture front end.
// Contents:
//   COARSE_W, FRAC_W, THERM_W, MAX_CNT  default widths / timeout
//   tdc_state_t                         capture FSM state encoding
//   coarse_t, frac_t                    result field types at default widths
package tdc_pkg;

    localparam int COARSE_W = 10;
    localparam int FRAC_W   = 7;
    localparam int THERM_W  = 128;
    localparam int MAX_CNT  = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ENC1 = 2'd2,
        ENC2 = 2'd3
    } tdc_state_t;

    typedef logic [COARSE_W-1:0] coarse_t;
    typedef logic [FRAC_W-1:0]   frac_t;

endpackage

// File: rtl/tdc_capture_if.sv
// tdc_capture_if: event inputs and result outputs of the TDC capture block.
// Signals:
//   tdc_start, tdc_stop  start/stop events, synchronous to clk
//   therm                delay-line thermometer taps
//   int_data, frac_data  coarse / fine result
//   out_dval             1-cycle result strobe
//   ovf                  result is a timeout (qualified by out_dval)
//   busy                 measurement in progress
// Modports: master drives events and observes results; slave is the capture block.
interface tdc_capture_if #(
    parameter int COARSE_W = 10,
    parameter int FRAC_W   = 7,
    parameter int THERM_W  = 128
);
    logic                tdc_start;
    logic                tdc_stop;
    logic [THERM_W-1:0]  therm;
    logic [COARSE_W-1:0] int_data;
    logic [FRAC_W-1:0]   frac_data;
    logic                out_dval;
    logic                ovf;
    logic                busy;

    modport master (
        output tdc_start, tdc_stop, therm,
        input  int_data, frac_data, out_dval, ovf, busy
    );

    modport slave (
        input  tdc_start, tdc_stop, therm,
        output int_data, frac_data, out_dval, ovf, busy
    );
endinterface

// File: rtl/tdc_therm_enc.sv
// tdc_therm_enc: 2-stage pipelined thermometer-to-binary encoder with saturation.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   therm       delay-line taps, sampled when capture=1
//   capture     load stage 1 from therm this edge
//   force_zero  treat taps as all zero (timeout capture)
//   frac        saturated fine value, valid two edges after capture
// Build option TDC_BUBBLE_FIX_EN:
//   defined   -> fine count = popcount (8 x 16-bit group counts, then sum)
//   undefined -> fine count = highest set tap index + 1 (priority encode)
module tdc_therm_enc #(
    parameter int THERM_W = 128,
    parameter int FRAC_W  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [THERM_W-1:0] therm,
    input  logic               capture,
    input  logic               force_zero,
    output logic [FRAC_W-1:0]  frac
);
    localparam int RAW_W   = $clog2(THERM_W + 1);
    localparam int SAT_MAX = (2 ** FRAC_W) - 1;

    logic [RAW_W-1:0]  raw;
    logic [FRAC_W-1:0] frac_q;

`ifdef TDC_BUBBLE_FIX_EN
    localparam int NGRP = (THERM_W + 15) / 16;

    logic [NGRP*16-1:0] bits;
    logic [4:0]         grp_d [NGRP];
    logic [4:0]         grp_q [NGRP];

    assign bits = force_zero ? '0 : (NGRP*16)'(therm);

    always_comb begin
        for (int unsigned g = 0; g < NGRP; g++) begin
            grp_d[g] = '0;
            for (int unsigned b = 0; b < 16; b++) begin
                grp_d[g] = grp_d[g] + 5'(bits[g*16 + b]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned g = 0; g < NGRP; g++) grp_q[g] <= '0;
        end else if (capture) begin
            for (int unsigned g = 0; g < NGRP; g++) grp_q[g] <= grp_d[g];
        end
    end

    always_comb begin
        raw = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            raw = raw + RAW_W'(grp_q[g]);
        end
    end
`else
    logic [THERM_W-1:0] bits;
    logic [RAW_W-1:0]   idx_d;
    logic [RAW_W-1:0]   idx_q;

    assign bits = force_zero ? '0 : therm;

    // Ascending scan so the highest set tap wins.
    always_comb begin
        idx_d = '0;
        for (int unsigned i = 0; i < THERM_W; i++) begin
            if (bits[i]) idx_d = RAW_W'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         idx_q <= '0;
        else if (capture) idx_q <= idx_d;
    end

    assign raw = idx_q;
`endif

    // Stage 2 free-runs: stage 1 holds between captures.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    frac_q <= '0;
        else if (int'(raw) > SAT_MAX) frac_q <= '1;
        else                         frac_q <= FRAC_W'(raw);
    end

    assign frac = frac_q;

endmodule

// File: rtl/tdc_capture.sv
// tdc_capture: TDC measurement front end. Counts coarse clock cycles from
// start to stop, captures the delay-line thermometer on stop, encodes it and
// emits one {int_data, frac_data} result with a 1-cycle out_dval strobe.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active low
//   bus   tdc_capture_if.slave: tdc_start, tdc_stop, therm in;
//         int_data, frac_data, out_dval, ovf, busy out
// Build option TDC_BUBBLE_FIX_EN selects the fine encoder (see tdc_therm_enc).
module tdc_capture
    import tdc_pkg::*;
#(
    parameter int COARSE_W = tdc_pkg::COARSE_W,
    parameter int FRAC_W   = tdc_pkg::FRAC_W,
    parameter int THERM_W  = tdc_pkg::THERM_W,
    parameter int MAX_CNT  = tdc_pkg::MAX_CNT
) (
    input  logic         clk,
    input  logic         rst,
    tdc_capture_if.slave bus
);
    localparam logic [COARSE_W-1:0] MAX_C = COARSE_W'(MAX_CNT);

    tdc_state_t state_q, state_d;

    logic [COARSE_W-1:0] count_q;
    logic [COARSE_W-1:0] cnt_next;
    logic                at_max;
    logic [COARSE_W-1:0] cap_int_q;
    logic                cap_ovf_q;
    logic [COARSE_W-1:0] int_q;
    logic [FRAC_W-1:0]   frac_q;
    logic                ovf_q;
    logic                dval_q;
    logic [FRAC_W-1:0]   enc_frac;

    logic busy_c, cap_en, cap_zero, emit;

    // Count register lags the edge by one, so the value for edge P is count+1.
    assign cnt_next = count_q + 1'b1;
    assign at_max   = (cnt_next == MAX_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.tdc_start) state_d = RUN;
            RUN:     if (bus.tdc_stop || at_max) state_d = ENC1;
            ENC1:    state_d = ENC2;
            ENC2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stop takes priority over timeout when both land on the same edge.
    always_comb begin
        busy_c   = (state_q != IDLE);
        cap_en   = (state_q == RUN) && (bus.tdc_stop || at_max);
        cap_zero = (state_q == RUN) && !bus.tdc_stop && at_max;
        emit     = (state_q == ENC2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            cap_int_q <= '0;
            cap_ovf_q <= 1'b0;
            int_q     <= '0;
            frac_q    <= '0;
            ovf_q     <= 1'b0;
            dval_q    <= 1'b0;
        end else begin
            dval_q <= 1'b0;
            if (state_q == IDLE && bus.tdc_start) begin
                count_q <= '0;
            end
            if (state_q == RUN) begin
                if (cap_en) begin
                    cap_int_q <= cap_zero ? MAX_C : cnt_next;
                    cap_ovf_q <= cap_zero;
                end else begin
                    count_q <= cnt_next;
                end
            end
            if (emit) begin
                int_q  <= cap_int_q;
                frac_q <= cap_ovf_q ? '0 : enc_frac;
                ovf_q  <= cap_ovf_q;
                dval_q <= 1'b1;
            end
        end
    end

    tdc_therm_enc #(
        .THERM_W (THERM_W),
        .FRAC_W  (FRAC_W)
    ) u_enc (
        .clk        (clk),
        .rst        (rst),
        .therm      (bus.therm),
        .capture    (cap_en),
        .force_zero (cap_zero),
        .frac       (enc_frac)
    );

    assign bus.int_data  = int_q;
    assign bus.frac_data = frac_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_dval  = dval_q;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_tdc_capture.sv
// tb_tdc_capture: scoreboard bench for tdc_capture at default parameters.
// Expected results are queued when stop (or a timeout start) is driven and
// compared when out_dval is seen, including the strobe edge.
module tb_tdc_capture;
    import tdc_pkg::*;

    typedef struct {
        int     idata;
        int     frac;
        bit     ovf;
        longint edge_no;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    exp_t   q[$];
    exp_t   got;

    tdc_capture_if #(.COARSE_W(10), .FRAC_W(7), .THERM_W(128)) bus ();

    tdc_capture #(
        .COARSE_W (10),
        .FRAC_W   (7),
        .THERM_W  (128),
        .MAX_CNT  (1023)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] ones(input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Result monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.out_dval) begin
            if (q.size() == 0) begin
                check_eq("spurious_dval", 1, 0);
            end else begin
                got = q.pop_front();
                check_eq("int_data", 64'(bus.int_data), 64'(got.idata));
                check_eq("frac_data", 64'(bus.frac_data), 64'(got.frac));
                check_eq("ovf", 64'(bus.ovf), 64'(got.ovf));
                check_eq("dval_edge", 64'(cyc), 64'(got.edge_no));
            end
        end
    end

    // One measurement of len cycles. both: stop also high at the start edge.
    // stop_start: start also high at the stop edge. noisy: extra start pulses
    // in RUN and ENC1 (needs len >= 3). Returns one edge after the stop edge,
    // so the next call's start lands on stop edge + 3.
    task automatic measure(input int len, input logic [127:0] th, input int ef,
                           input bit both, input bit stop_start, input bit noisy);
        exp_t   e;
        longint s;
        @(posedge clk);
        #1 bus.tdc_start = 1'b1; bus.tdc_stop = both;
        @(posedge clk);
        #1 bus.tdc_start = 1'b0; bus.tdc_stop = 1'b0;
        s = cyc;
        check_eq("busy_run", 64'(bus.busy), 1);
        if (noisy) begin
            @(posedge clk);
            #1 bus.tdc_start = 1'b1;
            @(posedge clk);
            #1 bus.tdc_start = 1'b0;
            repeat (len - 3) @(posedge clk);
        end else begin
            repeat (len - 1) @(posedge clk);
        end
        #1 bus.tdc_stop = 1'b1; bus.therm = th; bus.tdc_start = stop_start;
        e.idata = len; e.frac = ef; e.ovf = 1'b0; e.edge_no = s + len + 2;
        q.push_back(e);
        @(posedge clk);
        #1 bus.tdc_stop = 1'b0; bus.therm = '0; bus.tdc_start = noisy;
        @(posedge clk);
        #1 bus.tdc_start = 1'b0;
    endtask

    task automatic timeout_run();
        exp_t   e;
        longint s;
        @(posedge clk);
        #1 bus.tdc_start = 1'b1; bus.therm = ones(77);
        @(posedge clk);
        #1 bus.tdc_start = 1'b0;
        s = cyc;
        e.idata = 1023; e.frac = 0; e.ovf = 1'b1; e.edge_no = s + 1025;
        q.push_back(e);
        repeat (1023) @(posedge clk);
        @(posedge clk);
        #1 check_eq("busy_enc2", 64'(bus.busy), 1);
        @(posedge clk);
        #1 check_eq("busy_after_to", 64'(bus.busy), 0);
        bus.therm = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_int"}, 64'(bus.int_data), 0);
        check_eq({tag, "_frac"}, 64'(bus.frac_data), 0);
        check_eq({tag, "_ovf"}, 64'(bus.ovf), 0);
        check_eq({tag, "_dval"}, 64'(bus.out_dval), 0);
        check_eq({tag, "_busy"}, 64'(bus.busy), 0);
    endtask

    initial begin
        logic [127:0] th;
        int           n;
        int           len;
        int           budget;

        bus.tdc_start = 1'b0;
        bus.tdc_stop  = 1'b0;
        bus.therm     = '0;

        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst = 1'b1;

        measure(37, ones(40), 40, 0, 0, 0);
        measure(10, '1, 127, 0, 0, 0);
        th = ones(20);
        th[9] = 1'b0;
`ifdef TDC_BUBBLE_FIX_EN
        measure(12, th, 19, 0, 0, 0);
`else
        measure(12, th, 20, 0, 0, 0);
`endif
        measure(1, ones(0), 0, 0, 0, 0);
        measure(5, ones(3), 3, 1, 0, 0);
        measure(20, ones(64), 64, 0, 1, 1);
        measure(7, ones(100), 100, 0, 0, 0);
        timeout_run();
        measure(1023, ones(5), 5, 0, 0, 0);

        // Abort a measurement with reset; no strobe may follow.
        @(posedge clk);
        #1 bus.tdc_start = 1'b1;
        @(posedge clk);
        #1 bus.tdc_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_zero_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_eq("midrst_quiet_dval", 64'(bus.out_dval), 0);
        measure(9, ones(127), 127, 0, 0, 0);

        for (int k = 0; k < 5; k++) begin
            n   = int'($urandom_range(0, 128));
            len = int'($urandom_range(1, 50));
            measure(len, ones(n), (n > 127) ? 127 : n, 0, 0, 0);
        end

        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        check_eq("drain", 64'(q.size()), 0);
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
